// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Shares one 32-bit barrel shifter datapath (a right shifter and a left
//   shifter) between two requesters. Requests are arbitrated round-robin.
//   The winner's operands are latched, the shifters compute from those
//   registers, and the result is returned in a registered Y together with a
//   one-cycle DONE pulse for the requester that owns it.
//
//   Optional feature macro: SHIFT_ARB_ROTATE_EN
//     defined   : ROTx = 1 turns the selected shift into a rotate.
//     undefined : ROT0/ROT1 are ignored (ports kept for pin compatibility).
//
// Ports
//   CLK          in   system clock, rising edge
//   RST          in   synchronous active-high reset
//   REQ0/REQ1    in   request from requester 0/1
//   D0/D1        in   32-bit operand
//   S0/S1        in   5-bit shift amount
//   DIR0/DIR1    in   0 = logical right, 1 = left
//   ROT0/ROT1    in   rotate select (only with SHIFT_ARB_ROTATE_EN)
//   ACK0/ACK1    out  high during the EXEC cycle of that requester's operation
//   DONE0/DONE1  out  one-cycle pulse, Y holds that requester's result
//   Y            out  registered shared result, held until the next DONE
//   BUSY         out  high while in EXEC
module shift_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic [4:0]  S0,
  input  logic [4:0]  S1,
  input  logic        DIR0,
  input  logic        DIR1,
  input  logic        ROT0,
  input  logic        ROT1,
  output logic        ACK0,
  output logic        ACK1,
  output logic        DONE0,
  output logic        DONE1,
  output logic [31:0] Y,
  output logic        BUSY
);

  localparam int DATA_W = 32;
  localparam int SH_W   = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

`ifdef SHIFT_ARB_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  // Right shifter: the upper half of the 64-bit word carries the bits that
  // wrap around on a rotate, or zeros for a logical shift.
  function automatic logic [DATA_W-1:0] shift32_r(input logic [DATA_W-1:0] d,
                                                  input logic [SH_W-1:0]   s,
                                                  input logic              rot);
    logic [2*DATA_W-1:0] w;
    w = {(rot ? d : {DATA_W{1'b0}}), d} >> s;
    return w[DATA_W-1:0];
  endfunction

  // Left shifter: mirror image, result taken from the upper half.
  function automatic logic [DATA_W-1:0] shift32_l(input logic [DATA_W-1:0] d,
                                                  input logic [SH_W-1:0]   s,
                                                  input logic              rot);
    logic [2*DATA_W-1:0] w;
    w = {d, (rot ? d : {DATA_W{1'b0}})} << s;
    return w[2*DATA_W-1:DATA_W];
  endfunction

  logic [0:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic [DATA_W-1:0] op_d_q, op_d_d;
  logic [SH_W-1:0]   op_s_q, op_s_d;
  logic              op_dir_q, op_dir_d;
  logic              op_rot_q, op_rot_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] shift_res;

  always_comb begin
    shift_res = op_dir_q ? shift32_l(op_d_q, op_s_q, op_rot_q)
                         : shift32_r(op_d_q, op_s_q, op_rot_q);
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    op_d_d   = op_d_q;
    op_s_d   = op_s_q;
    op_dir_d = op_dir_q;
    op_rot_d = op_rot_q;
    y_d      = y_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          // On contention the requester that did not finish last wins.
          win_d    = (REQ0 && REQ1) ? ~last_q : REQ1;
          op_d_d   = win_d ? D1   : D0;
          op_s_d   = win_d ? S1   : S0;
          op_dir_d = win_d ? DIR1 : DIR0;
          op_rot_d = (win_d ? ROT1 : ROT0) & ROT_EN;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        y_d     = shift_res;
        done0_d = ~win_q;
        done1_d = win_q;
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and the visible result are reset; an aborted operation
  // therefore never produces DONE and leaves Y cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      y_q     <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      y_q     <= y_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  // Operand latches only matter while in EXEC, which reset leaves.
  always_ff @(posedge CLK) begin
    win_q    <= win_d;
    op_d_q   <= op_d_d;
    op_s_q   <= op_s_d;
    op_dir_q <= op_dir_d;
    op_rot_q <= op_rot_d;
  end

  assign BUSY  = (state_q == ST_EXEC);
  assign ACK0  = BUSY & ~win_q;
  assign ACK1  = BUSY & win_q;
  assign DONE0 = done0_q;
  assign DONE1 = done1_q;
  assign Y     = y_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [31:0] D0 = '0, D1 = '0;
  logic [4:0]  S0 = '0, S1 = '0;
  logic        DIR0 = 1'b0, DIR1 = 1'b0;
  logic        ROT0 = 1'b0, ROT1 = 1'b0;
  logic        ACK0, ACK1, DONE0, DONE1, BUSY;
  logic [31:0] Y;

  always #5 CLK = ~CLK;

  shift_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
    .D0(D0), .D1(D1), .S0(S0), .S1(S1),
    .DIR0(DIR0), .DIR1(DIR1), .ROT0(ROT0), .ROT1(ROT1),
    .ACK0(ACK0), .ACK1(ACK1), .DONE0(DONE0), .DONE1(DONE1),
    .Y(Y), .BUSY(BUSY)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [32:0] sb[$];
  logic [32:0] sb_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit-level reference for shift/rotate.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic dir, input logic rot);
    logic [31:0] r;
    int          k;
    logic        rot_on;
`ifdef SHIFT_ARB_ROTATE_EN
    rot_on = rot;
`else
    rot_on = 1'b0 & rot;
`endif
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (!dir) begin
        k = i + int'(s);
        if (k < 32) r[i] = d[k];
        else if (rot_on) r[i] = d[k-32];
      end else begin
        k = i - int'(s);
        if (k >= 0) r[i] = d[k];
        else if (rot_on) r[i] = d[k+32];
      end
    end
    return r;
  endfunction

  // Cycle model of the arbiter; pushes the expected result when a request is accepted.
  logic        m_exec, m_win, m_last, m_done0, m_done1;
  logic [31:0] m_res, m_y;
  logic        m_w;
  logic [31:0] m_r;

  always_comb begin
    m_w = (REQ0 && REQ1) ? ~m_last : REQ1;
    m_r = m_w ? ref_shift(D1, S1, DIR1, ROT1) : ref_shift(D0, S0, DIR0, ROT0);
  end

  always @(posedge CLK) begin
    if (RST) begin
      m_exec  <= 1'b0;
      m_last  <= 1'b1;
      m_y     <= '0;
      m_done0 <= 1'b0;
      m_done1 <= 1'b0;
      sb.delete();
    end else begin
      m_done0 <= 1'b0;
      m_done1 <= 1'b0;
      if (!m_exec) begin
        if (REQ0 || REQ1) begin
          m_exec <= 1'b1;
          m_win  <= m_w;
          m_res  <= m_r;
          sb.push_back({m_w, m_r});
        end
      end else begin
        m_exec  <= 1'b0;
        m_y     <= m_res;
        m_last  <= m_win;
        m_done0 <= ~m_win;
        m_done1 <= m_win;
      end
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      check("busy",  32'(BUSY),  32'(m_exec));
      check("ack0",  32'(ACK0),  32'(m_exec & ~m_win));
      check("ack1",  32'(ACK1),  32'(m_exec & m_win));
      check("done0", 32'(DONE0), 32'(m_done0));
      check("done1", 32'(DONE1), 32'(m_done1));
      check("y_hold", Y, m_y);
      if (DONE0 || DONE1) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          sb_e = sb.pop_front();
          check("done_id", 32'(DONE1), 32'(sb_e[32]));
          check("y_sb", Y, sb_e[31:0]);
        end
      end
    end
  end

  task automatic issue(input string tag, input bit id, input logic [31:0] d, input logic [4:0] s,
                       input logic dir, input logic rot, input logic [31:0] exp);
    bit got;
    @(posedge CLK); #1;
    if (id) begin D1 = d; S1 = s; DIR1 = dir; ROT1 = rot; REQ1 = 1'b1; end
    else    begin D0 = d; S0 = s; DIR0 = dir; ROT0 = rot; REQ0 = 1'b1; end
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge CLK);
      got = id ? ACK1 : ACK0;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    @(posedge CLK); #1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge CLK);
      got = id ? DONE1 : DONE0;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check(tag, Y, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          exp_id;
    int          n_done;
    logic [31:0] rd;
    logic [4:0]  rs;
    bit          rid, rdir, rrot;

    // Reset
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    mon_en = 1'b1;
    check("rst_y", Y, 32'h0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ack", 32'({ACK0, ACK1}), 32'd0);
    check("rst_done", 32'({DONE0, DONE1}), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("idle_busy", 32'(BUSY), 32'd0);
    end

    // Single operations
    issue("r_shift", 1'b0, 32'hffffffff, 5'd5, 1'b0, 1'b0, 32'h07ffffff);
    issue("l_shift", 1'b1, 32'h00000001, 5'd31, 1'b1, 1'b0, 32'h80000000);

    // Contention: requester 1 finished last, so 0 goes first
    @(posedge CLK); #1;
    D0 = 32'h9078af1b; S0 = 5'd20; DIR0 = 1'b0; ROT0 = 1'b0;
    D1 = 32'h7811bf90; S1 = 5'd4;  DIR1 = 1'b0; ROT1 = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("cont_first_ack0", 32'(ACK0), 32'd1);
    check("cont_first_ack1", 32'(ACK1), 32'd0);
    exp_id = 1'b0;
    n_done = 0;
    repeat (10) begin
      @(negedge CLK);
      if (DONE0 || DONE1) begin
        check("cont_alt", 32'(DONE1), 32'(exp_id));
        check("cont_y", Y, exp_id ? 32'h07811bf9 : 32'h00000907);
        exp_id = ~exp_id;
        n_done++;
      end
    end
    check("cont_rate", 32'(n_done), 32'd5);
    @(posedge CLK); #1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (4) @(negedge CLK);

    // REQ toggled during EXEC is ignored
    @(posedge CLK); #1;
    D1 = 32'h000000ff; S1 = 5'd7; DIR1 = 1'b1; ROT1 = 1'b0; REQ1 = 1'b1;
    @(posedge CLK); #1;
    REQ0 = 1'b1; D0 = 32'h12345678; S0 = 5'd3; DIR0 = 1'b0;
    @(negedge CLK);
    check("tog_ack1", 32'(ACK1), 32'd1);
    @(posedge CLK); #1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    check("tog_done1", 32'(DONE1), 32'd1);
    check("tog_y", Y, 32'h00007f80);
    repeat (3) begin
      @(negedge CLK);
      check("tog_no_ack0", 32'(ACK0), 32'd0);
    end

    // S = 0 passes data through; leaves requester 0 as last finisher
    issue("s0_pass", 1'b0, 32'h198af7b1, 5'd0, 1'b1, 1'b0, 32'h198af7b1);

    // Reset in the ACK cycle aborts the operation
    @(posedge CLK); #1;
    D0 = 32'hdeadbeef; S0 = 5'd3; DIR0 = 1'b0; REQ0 = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1; REQ0 = 1'b0;
    @(negedge CLK);
    check("abort_ack0", 32'(ACK0), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_done0", 32'(DONE0), 32'd0);
    check("abort_y", Y, 32'h0);
    check("abort_busy", 32'(BUSY), 32'd0);

    // First contention after reset goes to requester 0
    @(posedge CLK); #1;
    D0 = 32'h0000f000; S0 = 5'd12; DIR0 = 1'b0;
    D1 = 32'h0000000f; S1 = 5'd4;  DIR1 = 1'b1;
    REQ0 = 1'b1; REQ1 = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("post_rst_ack0", 32'(ACK0), 32'd1);
    @(posedge CLK); #1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    check("post_rst_y", Y, 32'h0000000f);
    repeat (3) @(negedge CLK);

    // Rotate select
`ifdef SHIFT_ARB_ROTATE_EN
    issue("rot_r", 1'b0, 32'h00000001, 5'd1, 1'b0, 1'b1, 32'h80000000);
`else
    issue("rot_r", 1'b0, 32'h00000001, 5'd1, 1'b0, 1'b1, 32'h00000000);
`endif

    // Random single operations
    for (int i = 0; i < 20; i++) begin
      rid  = 1'($urandom_range(0, 1));
      rd   = $urandom;
      rs   = 5'($urandom_range(0, 31));
      rdir = 1'($urandom_range(0, 1));
      rrot = 1'($urandom_range(0, 1));
      issue("rand", rid, rd, rs, rdir, rrot, ref_shift(rd, rs, rdir, rrot));
    end

    repeat (4) @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
